mem_write_buffer: RTL and testbench

//  Posted-write buffer between the compat_cache memory-side port and ram_mux port1.

---
 rtl/wbuf_pkg.sv | 25 ++
 rtl/wbuf_fifo.sv | 70 +++++++
 rtl/mem_write_buffer.sv | 191 +++++++++++++++++++
 tb/tb_mem_write_buffer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbuf_pkg.sv
// Shared types for the posted-write buffer: buffered entry layout and drain FSM states.
// Entry field widths here set the default address/data widths of mem_write_buffer.
package wbuf_pkg;

    localparam int WBUF_AW = 32;
    localparam int WBUF_DW = 32;
    localparam int WBUF_BW = WBUF_DW / 8;

    typedef struct packed {
        logic [WBUF_AW-1:0] addr;
        logic [WBUF_BW-1:0] be;
        logic [WBUF_DW-1:0] wdata;
    } wbuf_entry_t;

    localparam int WBUF_EW = $bits(wbuf_entry_t);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4
    } wbuf_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Synchronous DEPTH-entry FIFO of write entries; head readable combinationally, 1-cycle push-to-visible.
// Push is ignored when full, pop when empty; with WBUF_FWD_EN all entries are exposed oldest-first.
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WBUF_EW-1:0]       push_dat_i,
    input  logic                     pop_i,
    output logic [WBUF_EW-1:0]       head_o,
    output logic                     full_o,
    output logic                     empty_o
`ifdef WBUF_FWD_EN
    ,
    output logic [DEPTH*WBUF_EW-1:0] entries_o,
    output logic [DEPTH-1:0]         valid_o
`endif
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WBUF_EW-1:0] mem_q [DEPTH];
    logic               do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits coincide.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IW-1:0]] <= push_dat_i;
        end
    end

`ifdef WBUF_FWD_EN
    logic [PW-1:0] count;
    assign count = wr_ptr_q - rd_ptr_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [IW-1:0] idx;
        assign idx = rd_ptr_q[IW-1:0] + IW'(k);
        assign entries_o[k*WBUF_EW +: WBUF_EW] = mem_q[idx];
        assign valid_o[k] = (PW'(k) < count);
    end
`endif

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer: writes ack next cycle and drain in order; reads wait for drain (4-cycle latency at gnt=1).
// Write gnt drops while full or a read is pending; read gnt needs empty+idle. WBUF_FWD_EN adds full-be read forwarding.
module mem_write_buffer
    import wbuf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = WBUF_AW,
    parameter int DATA_WIDTH = WBUF_DW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      up_req_i,
    output logic                      up_gnt_o,
    output logic                      up_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]     up_addr_i,
    input  logic                      up_we_i,
    input  logic [DATA_WIDTH/8-1:0]   up_be_i,
    input  logic [DATA_WIDTH-1:0]     up_wdata_i,
    output logic [DATA_WIDTH-1:0]     up_rdata_o,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);
    wbuf_entry_t        push_ent, head_ent;
    logic [WBUF_EW-1:0] head_flat;
    logic               full, empty, pop;
    logic               wr_gnt, rd_gnt, fwd_gnt;
    logic [DATA_WIDTH-1:0] fwd_dat;

    wbuf_state_e           state_q, state_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  wr_rsp_q, wr_rsp_d;

    assign push_ent = '{addr: up_addr_i, be: up_be_i, wdata: up_wdata_i};
    assign head_ent = wbuf_entry_t'(head_flat);

`ifdef WBUF_FWD_EN
    logic [DEPTH*WBUF_EW-1:0] fifo_ents;
    logic [DEPTH-1:0]         fifo_vld;
    logic                     fwd_hit;
    wbuf_entry_t              cand;

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (wr_gnt),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_o     (head_flat),
        .full_o     (full),
        .empty_o    (empty),
        .entries_o  (fifo_ents),
        .valid_o    (fifo_vld)
    );

    // Entries are scanned oldest-first so the youngest matching write decides.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        cand    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cand = wbuf_entry_t'(fifo_ents[k*WBUF_EW +: WBUF_EW]);
            if (fifo_vld[k] && (cand.addr == up_addr_i)) begin
                fwd_hit = &cand.be;
                fwd_dat = cand.wdata;
            end
        end
    end

    assign fwd_gnt = up_req_i & ~up_we_i & ~empty & fwd_hit & ~rd_pend_q;
`else
    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (wr_gnt),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_o     (head_flat),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign fwd_gnt = 1'b0;
    assign fwd_dat = '0;
`endif

    // full comes from registered pointers only, so a same-cycle pop never opens the write grant.
    assign wr_gnt   = up_req_i & up_we_i & ~full & ~rd_pend_q;
    assign rd_gnt   = up_req_i & ~up_we_i & empty & (state_q == IDLE) & ~rd_pend_q & ~wr_rsp_q;
    assign up_gnt_o = wr_gnt | rd_gnt | fwd_gnt;

    assign up_rvalid_o = rsp_vld_q;
    assign up_rdata_o  = rsp_dat_q;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        rsp_vld_d   = 1'b0;
        rsp_dat_d   = '0;
        wr_rsp_d    = wr_gnt;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;

        if (wr_gnt) begin
            rsp_vld_d = 1'b1;
        end
        if (rd_gnt) begin
            rd_pend_d = 1'b1;
            rd_addr_d = up_addr_i;
        end
        if (fwd_gnt) begin
            rsp_vld_d = 1'b1;
            rsp_dat_d = fwd_dat;
        end

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = WR_REQ;
                end else if (rd_pend_q) begin
                    state_d = RD_REQ;
                end
            end
            WR_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = head_ent.addr;
                mem_be_o    = head_ent.be;
                mem_wdata_o = head_ent.wdata;
                if (mem_gnt_i) begin
                    pop     = 1'b1;
                    state_d = WR_RSP;
                end
            end
            WR_RSP: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = rd_addr_q;
                mem_be_o   = '1;
                if (mem_gnt_i) begin
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                if (mem_rvalid_i) begin
                    rsp_vld_d = 1'b1;
                    rsp_dat_d = mem_rdata_i;
                    rd_pend_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            wr_rsp_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            wr_rsp_q  <= wr_rsp_d;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: directed scenarios then random traffic against an ordered memory model.
module tb_mem_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        up_req_i, up_gnt_o, up_rvalid_o, up_we_i;
    logic [31:0] up_addr_i, up_wdata_i, up_rdata_o;
    logic [3:0]  up_be_i;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    always #5 clk = ~clk;

    mem_write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_req_i     (up_req_i),
        .up_gnt_o     (up_gnt_o),
        .up_rvalid_o  (up_rvalid_o),
        .up_addr_i    (up_addr_i),
        .up_we_i      (up_we_i),
        .up_be_i      (up_be_i),
        .up_wdata_i   (up_wdata_i),
        .up_rdata_o   (up_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          gmode = 1;        // 0: gnt held low, 1: gnt tied high, 2: random gnt
    int          n_mem_rd = 0;
    logic [31:0] exp_q [$];
    logic [31:0] wlog_a [$];
    logic [31:0] wlog_d [$];
    logic [31:0] ram [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RAM side: one-cycle rvalid after each accepted request.
    initial begin
        logic        hs, we;
        logic [31:0] a, d;
        logic [3:0]  be;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            hs = (rst_n === 1'b1) && mem_req_o && mem_gnt_i;
            a = mem_addr_o; d = mem_wdata_o; be = mem_be_o; we = mem_we_o;
            @(posedge clk); #1;
            mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            if (hs) begin
                mem_rvalid_i = 1'b1;
                if (we) begin
                    ram[a] = merge(ram_rd(a), d, be);
                    wlog_a.push_back(a); wlog_d.push_back(d);
                end else begin
                    mem_rdata_i = ram_rd(a);
                    n_mem_rd++;
                end
            end
            mem_gnt_i = (gmode == 2) ? 1'($urandom_range(0, 1)) : (gmode != 0);
        end
    end

    // Every upstream response must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && up_rvalid_o === 1'b1) begin
                if (exp_q.size() == 0) check("rsp_unexpected", up_rvalid_o, 1'b0);
                else check("rsp_data", up_rdata_o, exp_q.pop_front());
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                            input int budget, output int gc);
        gc = -1;
        up_req_i = 1'b1; up_we_i = 1'b1; up_addr_i = a; up_be_i = be; up_wdata_i = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (up_gnt_o) begin
                gc = cyc;
                ref_mem[a] = merge(ref_rd(a), d, be);
                exp_q.push_back(32'h0);
                break;
            end
            @(posedge clk); #1;
        end
        if (gc >= 0) begin @(posedge clk); #1; end
        up_req_i = 1'b0; up_we_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int budget, output int gc);
        gc = -1;
        up_req_i = 1'b1; up_we_i = 1'b0; up_addr_i = a; up_be_i = 4'hF;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (up_gnt_o) begin
                gc = cyc;
                exp_q.push_back(ref_rd(a));
                break;
            end
            @(posedge clk); #1;
        end
        if (gc >= 0) begin @(posedge clk); #1; end
        up_req_i = 1'b0;
    endtask

    task automatic wait_rvalid(input int budget, output int rc, output logic [31:0] rd);
        rc = -1; rd = 'x;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (up_rvalid_o) begin rc = cyc; rd = up_rdata_o; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gc, gr, rq, rc, rd0;
        logic [31:0] rd, a, pre [3];

        rst_n = 1'b0; up_req_i = 1'b0; up_we_i = 1'b0;
        up_addr_i = '0; up_be_i = '0; up_wdata_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        @(negedge clk);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_up_rvalid", up_rvalid_o, 1'b0);
        check("rst_up_rdata", up_rdata_o, 32'h0);
        check("rst_gnt_idle", up_gnt_o, 1'b0);
        up_req_i = 1'b1; up_we_i = 1'b1;
        #1 check("rst_gnt_follows_req", up_gnt_o, 1'b1);
        @(posedge clk); #1;
        up_req_i = 1'b0; up_we_i = 1'b0; rst_n = 1'b1;
        idle(2);

        // 1: single write
        do_write(32'h0010_0000, 4'hF, 32'h1234_ABCD, 1, gc);
        check("t1_gnt_same_cycle", gc >= 0, 1'b1);
        wait_rvalid(5, rc, rd);
        check("t1_rvalid_next", rc - gc, 1);
        check("t1_wr_rdata_zero", rd, 32'h0);
        idle(8);
        check("t1_mem_wr_count", wlog_a.size(), 1);
        check("t1_mem_addr", (wlog_a.size() > 0) ? wlog_a[0] : 32'hDEAD_DEAD, 32'h0010_0000);
        check("t1_mem_wdata", (wlog_d.size() > 0) ? wlog_d[0] : 32'hDEAD_DEAD, 32'h1234_ABCD);
        check("t1_ram_word", ram_rd(32'h0010_0000), 32'h1234_ABCD);

        // 2: read back after drain
        do_read(32'h0010_0000, 50, gc);
        check("t2_rd_gnt", gc >= 0, 1'b1);
        wait_rvalid(20, rc, rd);
        check("t2_rd_latency", rc - gc, 4);
        check("t2_rdata", rd, 32'h1234_ABCD);

        // 3: burst against a stalled RAM
        gmode = 0; idle(2);
        wlog_a.delete(); wlog_d.delete();
        for (int i = 0; i < 4; i++) begin
            do_write(32'h400 + 32'(4*i), 4'hF, 32'hC0DE_0000 + 32'(i), 1, gc);
            check("t3_burst_gnt", gc >= 0, 1'b1);
        end
        do_write(32'h410, 4'hF, 32'hC0DE_0004, 4, gc);
        check("t3_fifth_blocked", gc >= 0, 1'b0);
        gmode = 1;
        do_write(32'h410, 4'hF, 32'hC0DE_0004, 20, gc);
        check("t3_fifth_after_pop", gc >= 0, 1'b1);
        idle(30);
        check("t3_drain_count", wlog_a.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("t3_ram_order", (wlog_a.size() > i) ? wlog_a[i] : 32'hDEAD_DEAD, 32'h400 + 32'(4*i));
            check("t3_ram_data", ram_rd(32'h400 + 32'(4*i)), 32'hC0DE_0000 + 32'(i));
        end

        // 4: write then immediate read of the same word
        rd0 = n_mem_rd;
        do_write(32'h10, 4'hF, 32'hFEED_0010, 1, gc);
        rq = cyc;
        do_read(32'h10, 50, gr);
        wait_rvalid(20, rc, rd);
        check("t4_rdata", rd, 32'hFEED_0010);
`ifdef WBUF_FWD_EN
        check("t4_fwd_gnt_now", gr - rq, 0);
        check("t4_fwd_latency", rc - gr, 1);
        check("t4_no_mem_read", n_mem_rd - rd0, 0);
`else
        check("t4_rd_waits_drain", (gr - rq) > 0, 1'b1);
        check("t4_rd_latency", rc - gr, 4);
        check("t4_one_mem_read", n_mem_rd - rd0, 1);
`endif
        idle(5);

        // 5: partial-byte write then read of the same word
        rd0 = n_mem_rd;
        do_write(32'h20, 4'b0011, 32'hAAAA_BBBB, 1, gc);
        do_read(32'h20, 50, gr);
        wait_rvalid(20, rc, rd);
        check("t5_merged_rdata", rd, merge(init_val(32'h20), 32'hAAAA_BBBB, 4'b0011));
        check("t5_rd_latency", rc - gr, 4);
        check("t5_mem_read_issued", n_mem_rd - rd0, 1);
        idle(5);

        // 6: reset while a write is stuck in the request phase
        gmode = 0; idle(2);
        for (int i = 0; i < 3; i++) begin
            a = 32'h500 + 32'(4*i);
            pre[i] = ref_rd(a);
            do_write(a, 4'hF, 32'h6000_0000 + 32'(i), 1, gc);
        end
        idle(3);
        @(negedge clk);
        check("t6_in_wr_req", {mem_req_o, mem_we_o}, 2'b11);
        check("t6_wr_req_addr", mem_addr_o, 32'h500);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) ref_mem[32'h500 + 32'(4*i)] = pre[i];
        gmode = 1;
        @(negedge clk);
        check("t6_mem_req_cleared", mem_req_o, 1'b0);
        check("t6_rvalid_cleared", up_rvalid_o, 1'b0);
        @(posedge clk); #1;
        rq = cyc;
        do_read(32'h504, 10, gr);
        check("t6_empty_after_rst", gr - rq, 0);
        wait_rvalid(20, rc, rd);
        check("t6_old_ram_value", rd, pre[1]);
        idle(10);
        check("t6_no_stale_write", ram.exists(32'h500), 1'b0);

        // Random traffic against the ordered model with a jittery RAM grant
        gmode = 2;
        for (int n = 0; n < 80; n++) begin
            a = 32'h300 + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_write(a, 4'($urandom_range(1, 15)), $urandom, 200, gc);
            else
                do_read(a, 200, gc);
            check("rnd_gnt", gc >= 0, 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        gmode = 1;
        idle(40);
        check("rnd_all_responded", exp_q.size(), 0);
        for (int k = 0; k < 8; k++) begin
            a = 32'h300 + 32'(4*k);
            check("rnd_ram_final", ram_rd(a), ref_rd(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
